icw_sequencer: RTL and testbench
================================

ICW_SEQUENCER -- requirements
Module: icw_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset; all other inputs are synchronous to clk.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 rstn  input  1  asynchronous active-low reset.
REQ-004 csn  input  1  chip select, active low.
REQ-005 wrn  input  1  write strobe, active low.
REQ-006 rdn  input  1  read strobe, active low; used only to qualify writes.
REQ-007 a0  input  1  register address bit.
REQ-008 din  input  8  data from the data bus buffer.
REQ-009 init_done  output  1  high when the ICW sequence is complete (READY).
REQ-010 seq_state  output  3  current state encoding: IDLE=0, ICW2=1, ICW3=2, ICW4=3, READY=4.
REQ-011 vec_base  output  5  ICW2 din[7:3].
REQ-012 ltim, sngl, ic4  output  1 each  ICW1 din[3], din[1], din[0].
REQ-013 icw3  output  8  ICW3 byte.
REQ-014 aeoi, upm  output  1 each  ICW4 din[1], din[0].
REQ-015 imr  output  8  interrupt mask register (OCW1).
REQ-016 ocw2_stb  output  1  one-cycle pulse on an OCW2 commit.
REQ-017 ocw2_cmd, ocw2_lvl  output  3 each  OCW2 din[7:5] and din[2:0], held until the next OCW2.
REQ-018 ris_sel, smm  output  1 each  read-ISR select and special-mask-mode flags (OCW3).
REQ-019 poll_stb  output  1  one-cycle pulse on an OCW3 commit with P=1.

Function
REQ-020 Capture: on every edge with csn=0, wrn=0, rdn=1, the block SHALL register {a0, din} and set an internal valid flag; a later capture in the same strobe overwrites the earlier one.
REQ-021 Commit: on the first edge with wrn=1 and valid=1, the block SHALL decode the captured byte, update its outputs on that same edge, and clear valid.
REQ-022 Abort: an edge with csn=1 or rdn=0 while wrn=0 SHALL clear valid, so that no commit follows.
REQ-023 ICW1 (a0=0, din[4]=1) SHALL be accepted in any state: load ltim/sngl/ic4, set imr=8'h00, ris_sel=0, smm=0, clear aeoi/upm, and go to ICW2.
REQ-024 In IDLE, every commit other than ICW1 SHALL be ignored.
REQ-025 In ICW2, a commit with a0=1 SHALL load vec_base, then go to ICW3 if sngl=0, else ICW4 if ic4=1, else READY.
REQ-026 In ICW3, a commit with a0=1 SHALL load icw3, then go to ICW4 if ic4=1, else READY.
REQ-027 In ICW4, a commit with a0=1 SHALL load aeoi/upm and go to READY.
REQ-028 In ICW2/3/4, a commit with a0=0 that is not ICW1 SHALL be ignored and the state held.
REQ-029 In READY, a0=1 SHALL load imr=din (OCW1).
REQ-030 In READY, a0=0 with din[4:3]=00 SHALL load ocw2_cmd/ocw2_lvl and pulse ocw2_stb (OCW2).
REQ-031 In READY, a0=0 with din[4:3]=01 is OCW3 and SHALL:
- set ris_sel=din[0] only if din[1]=1;
- set smm=din[5] only if din[6]=1;
- pulse poll_stb if din[2]=1.
REQ-032 init_done SHALL equal (seq_state==READY); ocw2_stb and poll_stb SHALL never be high in consecutive cycles from one commit.

Reset
REQ-033 rstn=0 SHALL immediately set seq_state=IDLE, valid=0, imr=8'hFF, and every other output to 0, including mid-strobe or mid-sequence.
REQ-034 A strobe in progress when rstn deasserts SHALL NOT commit, because valid has been cleared.

Verification
REQ-035 Reset; ICW1=0x13 (sngl=1, ic4=1), ICW2=0x20 (a0=1), ICW4=0x03 -> vec_base=5'h04, aeoi=1, upm=1, init_done=1; ICW3 skipped.
REQ-036 ICW1=0x10, ICW2=0x48, ICW3=0x04 -> icw3=0x04, READY after ICW3, ic4=0 so ICW4 skipped; imr=0x00.
REQ-037 In READY: OCW1=0xA5 -> imr=0xA5; OCW2=0x63 -> ocw2_cmd=3'b011, ocw2_lvl=3'b011, exactly one ocw2_stb; OCW3=0x0B -> ris_sel=1; OCW3=0x0C -> one poll_stb, ris_sel still 1.
REQ-038 Mid-sequence re-init: in ICW3 write ICW1=0x17 -> state ICW2, imr=0x00; a0=0 OCW-type write in ICW2 -> ignored.
REQ-039 Abort and qualify:
- csn rises while wrn low -> no commit;
- rdn=0 during wrn low -> no commit;
- a0=1 write in IDLE -> ignored;
- rstn pulse mid-strobe -> imr=0xFF, IDLE, no commit after release.

Source files
------------

// File: rtl/icw_sequencer.sv
// Initialization command word sequencer for an 8259-style interrupt controller.
// Captures bus writes, commits them when the write strobe ends, and walks ICW1..ICW4 before accepting OCWs.
module icw_sequencer (
    input  logic       clk,
    input  logic       rstn,
    input  logic       csn,
    input  logic       wrn,
    input  logic       rdn,
    input  logic       a0,
    input  logic [7:0] din,
    output logic       init_done,
    output logic [2:0] seq_state,
    output logic [4:0] vec_base,
    output logic       ltim,
    output logic       sngl,
    output logic       ic4,
    output logic [7:0] icw3,
    output logic       aeoi,
    output logic       upm,
    output logic [7:0] imr,
    output logic       ocw2_stb,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_lvl,
    output logic       ris_sel,
    output logic       smm,
    output logic       poll_stb
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ICW2  = 3'd1,
        S_ICW3  = 3'd2,
        S_ICW4  = 3'd3,
        S_READY = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [8:0] cap_q, cap_d;
    logic       valid_q, valid_d;
    logic [4:0] vec_base_q, vec_base_d;
    logic       ltim_q, ltim_d, sngl_q, sngl_d, ic4_q, ic4_d;
    logic [7:0] icw3_q, icw3_d, imr_q, imr_d;
    logic       aeoi_q, aeoi_d, upm_q, upm_d;
    logic [2:0] ocw2_cmd_q, ocw2_cmd_d, ocw2_lvl_q, ocw2_lvl_d;
    logic       ris_sel_q, ris_sel_d, smm_q, smm_d;
    logic       ocw2_stb_q, ocw2_stb_d, poll_stb_q, poll_stb_d;

    logic       commit, cap_a0, is_icw1, in_ready, data_wr;
    logic [7:0] cap_din;

    // A commit is the first edge after the strobe ends with a capture still pending.
    assign commit   = wrn && valid_q;
    assign cap_a0   = cap_q[8];
    assign cap_din  = cap_q[7:0];
    assign is_icw1  = commit && !cap_a0 && cap_din[4];
    assign in_ready = commit && !is_icw1 && (state_q == S_READY);
    assign data_wr  = commit && cap_a0;

    // Capture / abort of the write strobe.
    always_comb begin
        cap_d   = cap_q;
        valid_d = valid_q;
        if (!wrn) begin
            if (!csn && rdn) begin
                cap_d   = {a0, din};
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end else if (valid_q) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (is_icw1) begin
            state_d = S_ICW2;
        end else if (data_wr) begin
            case (state_q)
                S_ICW2:  state_d = !sngl_q ? S_ICW3 : (ic4_q ? S_ICW4 : S_READY);
                S_ICW3:  state_d = ic4_q ? S_ICW4 : S_READY;
                S_ICW4:  state_d = S_READY;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        seq_state = state_q;
        init_done = (state_q == S_READY);
    end

    always_comb begin
        vec_base_d = vec_base_q;
        ltim_d     = ltim_q;
        sngl_d     = sngl_q;
        ic4_d      = ic4_q;
        icw3_d     = icw3_q;
        aeoi_d     = aeoi_q;
        upm_d      = upm_q;
        imr_d      = imr_q;
        ocw2_cmd_d = ocw2_cmd_q;
        ocw2_lvl_d = ocw2_lvl_q;
        ris_sel_d  = ris_sel_q;
        smm_d      = smm_q;
        ocw2_stb_d = 1'b0;
        poll_stb_d = 1'b0;
        if (is_icw1) begin
            ltim_d    = cap_din[3];
            sngl_d    = cap_din[1];
            ic4_d     = cap_din[0];
            imr_d     = 8'h00;
            ris_sel_d = 1'b0;
            smm_d     = 1'b0;
            aeoi_d    = 1'b0;
            upm_d     = 1'b0;
        end else if (data_wr && state_q == S_ICW2) begin
            vec_base_d = cap_din[7:3];
        end else if (data_wr && state_q == S_ICW3) begin
            icw3_d = cap_din;
        end else if (data_wr && state_q == S_ICW4) begin
            aeoi_d = cap_din[1];
            upm_d  = cap_din[0];
        end else if (in_ready && cap_a0) begin
            imr_d = cap_din;
        end else if (in_ready && cap_din[4:3] == 2'b00) begin
            ocw2_cmd_d = cap_din[7:5];
            ocw2_lvl_d = cap_din[2:0];
            ocw2_stb_d = 1'b1;
        end else if (in_ready && cap_din[4:3] == 2'b01) begin
            if (cap_din[1]) ris_sel_d = cap_din[0];
            if (cap_din[6]) smm_d = cap_din[5];
            poll_stb_d = cap_din[2];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cap_q      <= 9'd0;
            valid_q    <= 1'b0;
            vec_base_q <= 5'd0;
            ltim_q     <= 1'b0;
            sngl_q     <= 1'b0;
            ic4_q      <= 1'b0;
            icw3_q     <= 8'h00;
            aeoi_q     <= 1'b0;
            upm_q      <= 1'b0;
            imr_q      <= 8'hFF;
            ocw2_cmd_q <= 3'd0;
            ocw2_lvl_q <= 3'd0;
            ris_sel_q  <= 1'b0;
            smm_q      <= 1'b0;
            ocw2_stb_q <= 1'b0;
            poll_stb_q <= 1'b0;
        end else begin
            cap_q      <= cap_d;
            valid_q    <= valid_d;
            vec_base_q <= vec_base_d;
            ltim_q     <= ltim_d;
            sngl_q     <= sngl_d;
            ic4_q      <= ic4_d;
            icw3_q     <= icw3_d;
            aeoi_q     <= aeoi_d;
            upm_q      <= upm_d;
            imr_q      <= imr_d;
            ocw2_cmd_q <= ocw2_cmd_d;
            ocw2_lvl_q <= ocw2_lvl_d;
            ris_sel_q  <= ris_sel_d;
            smm_q      <= smm_d;
            ocw2_stb_q <= ocw2_stb_d;
            poll_stb_q <= poll_stb_d;
        end
    end

    assign vec_base = vec_base_q;
    assign ltim     = ltim_q;
    assign sngl     = sngl_q;
    assign ic4      = ic4_q;
    assign icw3     = icw3_q;
    assign aeoi     = aeoi_q;
    assign upm      = upm_q;
    assign imr      = imr_q;
    assign ocw2_cmd = ocw2_cmd_q;
    assign ocw2_lvl = ocw2_lvl_q;
    assign ris_sel  = ris_sel_q;
    assign smm      = smm_q;
    assign ocw2_stb = ocw2_stb_q;
    assign poll_stb = poll_stb_q;
endmodule

// File: tb/tb_icw_sequencer.sv
// Bench for icw_sequencer: directed ICW/OCW scenarios plus a randomized run
// checked against a behavioural model of the command-word rules.
module tb_icw_sequencer;
    localparam logic [2:0] ST_IDLE = 3'd0, ST_ICW2 = 3'd1, ST_ICW3 = 3'd2, ST_ICW4 = 3'd3, ST_READY = 3'd4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       csn = 1'b1;
    logic       wrn = 1'b1;
    logic       rdn = 1'b1;
    logic       a0 = 1'b0;
    logic [7:0] din = 8'h00;
    logic       init_done, ltim, sngl, ic4, aeoi, upm, ocw2_stb, ris_sel, smm, poll_stb;
    logic [2:0] seq_state, ocw2_cmd, ocw2_lvl;
    logic [4:0] vec_base;
    logic [7:0] icw3, imr;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    icw_sequencer dut (
        .clk(clk), .rstn(rstn), .csn(csn), .wrn(wrn), .rdn(rdn), .a0(a0), .din(din),
        .init_done(init_done), .seq_state(seq_state), .vec_base(vec_base),
        .ltim(ltim), .sngl(sngl), .ic4(ic4), .icw3(icw3), .aeoi(aeoi), .upm(upm),
        .imr(imr), .ocw2_stb(ocw2_stb), .ocw2_cmd(ocw2_cmd), .ocw2_lvl(ocw2_lvl),
        .ris_sel(ris_sel), .smm(smm), .poll_stb(poll_stb)
    );

    // Behavioural model: what the programmer-visible registers should hold.
    logic [2:0] e_state;
    logic [4:0] e_vec;
    logic       e_ltim, e_sngl, e_ic4, e_aeoi, e_upm, e_ris, e_smm;
    logic [7:0] e_icw3, e_imr;
    logic [2:0] e_cmd, e_lvl;

    task automatic model_reset();
        e_state = ST_IDLE; e_vec = 0; e_ltim = 0; e_sngl = 0; e_ic4 = 0;
        e_aeoi = 0; e_upm = 0; e_ris = 0; e_smm = 0;
        e_icw3 = 0; e_imr = 8'hFF; e_cmd = 0; e_lvl = 0;
    endtask

    task automatic model_commit(input logic ma0, input logic [7:0] md, output int x_ocw2, output int x_poll);
        x_ocw2 = 0;
        x_poll = 0;
        if (!ma0 && md[4]) begin
            e_ltim = md[3]; e_sngl = md[1]; e_ic4 = md[0];
            e_imr = 8'h00; e_ris = 0; e_smm = 0; e_aeoi = 0; e_upm = 0;
            e_state = ST_ICW2;
        end else if (e_state == ST_ICW2 && ma0) begin
            e_vec = md[7:3];
            if (!e_sngl) e_state = ST_ICW3;
            else if (e_ic4) e_state = ST_ICW4;
            else e_state = ST_READY;
        end else if (e_state == ST_ICW3 && ma0) begin
            e_icw3 = md;
            e_state = e_ic4 ? ST_ICW4 : ST_READY;
        end else if (e_state == ST_ICW4 && ma0) begin
            e_aeoi = md[1]; e_upm = md[0];
            e_state = ST_READY;
        end else if (e_state == ST_READY) begin
            if (ma0) begin
                e_imr = md;
            end else if (md[4:3] == 2'b00) begin
                e_cmd = md[7:5]; e_lvl = md[2:0]; x_ocw2 = 1;
            end else begin
                if (md[1]) e_ris = md[0];
                if (md[6]) e_smm = md[5];
                if (md[2]) x_poll = 1;
            end
        end
    endtask

    function automatic logic [37:0] exp_vec();
        return {e_state, (e_state == ST_READY), e_vec, e_ltim, e_sngl, e_ic4, e_icw3,
                e_aeoi, e_upm, e_imr, e_cmd, e_lvl, e_ris, e_smm};
    endfunction

    function automatic logic [37:0] dut_vec();
        return {seq_state, init_done, vec_base, ltim, sngl, ic4, icw3,
                aeoi, upm, imr, ocw2_cmd, ocw2_lvl, ris_sel, smm};
    endfunction

    // One write strobe of 1..3 cycles; earlier cycles carry junk that the last capture overwrites.
    task automatic bus_write(input logic wa0, input logic [7:0] wd, output int n_ocw2, output int n_poll);
        int hold;
        hold = $urandom_range(1, 3);
        @(negedge clk);
        csn = 0; wrn = 0; rdn = 1;
        for (int i = 0; i < hold; i++) begin
            if (i == hold - 1) begin
                a0 = wa0; din = wd;
            end else begin
                a0 = 1'($urandom); din = 8'($urandom);
            end
            @(negedge clk);
        end
        wrn = 1; csn = 1; a0 = 1'($urandom); din = 8'($urandom);
        n_ocw2 = 0;
        n_poll = 0;
        repeat (3) begin
            @(negedge clk);
            n_ocw2 += int'(ocw2_stb);
            n_poll += int'(poll_stb);
        end
    endtask

    // kind 0: csn rises while wrn low; kind 1: rdn drops while wrn low.
    task automatic bus_abort(input int kind, input logic wa0, input logic [7:0] wd, output int n_ocw2, output int n_poll);
        @(negedge clk);
        csn = 0; wrn = 0; rdn = 1; a0 = wa0; din = wd;
        @(negedge clk);
        if (kind == 0) csn = 1;
        else rdn = 0;
        @(negedge clk);
        wrn = 1; csn = 1; rdn = 1;
        n_ocw2 = 0;
        n_poll = 0;
        repeat (3) begin
            @(negedge clk);
            n_ocw2 += int'(ocw2_stb);
            n_poll += int'(poll_stb);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1;
        @(negedge clk);
        #2 rstn = 0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_regs: got %h want %h", dut_vec(), exp_vec());
        end
        n_cmp++;
        if (imr !== 8'hFF || seq_state !== ST_IDLE) begin
            n_fail++; $display("FAIL reset_imr_state: got imr=%h st=%0d want imr=ff st=0", imr, seq_state);
        end
        n_cmp++;
        if (ocw2_stb !== 1'b0 || poll_stb !== 1'b0) begin
            n_fail++; $display("FAIL reset_strobes: got %b%b want 00", ocw2_stb, poll_stb);
        end
        @(negedge clk);
        rstn = 1;
    endtask

    task automatic test_init_single_ic4();
        logic       t_a0[3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] t_d[3]  = '{8'h13, 8'h20, 8'h03};
        logic [2:0] t_st[3] = '{ST_ICW2, ST_ICW4, ST_READY};
        int no, np, xo, xp;
        for (int i = 0; i < 3; i++) begin
            bus_write(t_a0[i], t_d[i], no, np);
            model_commit(t_a0[i], t_d[i], xo, xp);
            n_cmp++;
            if (dut_vec() !== exp_vec() || seq_state !== t_st[i]) begin
                n_fail++; $display("FAIL init_single step%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (vec_base !== 5'h04 || aeoi !== 1 || upm !== 1 || init_done !== 1) begin
            n_fail++; $display("FAIL init_single_final: got vec=%h aeoi=%b upm=%b done=%b want 04 1 1 1",
                               vec_base, aeoi, upm, init_done);
        end
    endtask

    task automatic test_init_cascade();
        logic       t_a0[3] = '{1'b0, 1'b1, 1'b1};
        logic [7:0] t_d[3]  = '{8'h10, 8'h48, 8'h04};
        logic [2:0] t_st[3] = '{ST_ICW2, ST_ICW3, ST_READY};
        int no, np, xo, xp;
        for (int i = 0; i < 3; i++) begin
            bus_write(t_a0[i], t_d[i], no, np);
            model_commit(t_a0[i], t_d[i], xo, xp);
            n_cmp++;
            if (dut_vec() !== exp_vec() || seq_state !== t_st[i]) begin
                n_fail++; $display("FAIL init_cascade step%0d: got %h want %h", i, dut_vec(), exp_vec());
            end
        end
        n_cmp++;
        if (icw3 !== 8'h04 || imr !== 8'h00 || vec_base !== 5'h09 || ic4 !== 0) begin
            n_fail++; $display("FAIL init_cascade_final: got icw3=%h imr=%h vec=%h want 04 00 09", icw3, imr, vec_base);
        end
    endtask

    task automatic test_ready_ocws();
        logic       t_a0[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        logic [7:0] t_d[5]  = '{8'hA5, 8'h63, 8'h0B, 8'h0C, 8'h68};
        int no, np, xo, xp;
        for (int i = 0; i < 5; i++) begin
            bus_write(t_a0[i], t_d[i], no, np);
            model_commit(t_a0[i], t_d[i], xo, xp);
            n_cmp++;
            if (dut_vec() !== exp_vec() || no !== xo || np !== xp) begin
                n_fail++; $display("FAIL ready_ocw %h: got %h o%0d p%0d want %h o%0d p%0d",
                                   t_d[i], dut_vec(), no, np, exp_vec(), xo, xp);
            end
            if (i == 1) begin
                n_cmp++;
                if (ocw2_cmd !== 3'b011 || ocw2_lvl !== 3'b011 || no !== 1) begin
                    n_fail++; $display("FAIL ocw2_63: got cmd=%b lvl=%b pulses=%0d want 011 011 1", ocw2_cmd, ocw2_lvl, no);
                end
            end
            if (i == 3) begin
                n_cmp++;
                if (ris_sel !== 1 || np !== 1 || imr !== 8'hA5) begin
                    n_fail++; $display("FAIL ocw3_0c: got ris=%b polls=%0d imr=%h want 1 1 a5", ris_sel, np, imr);
                end
            end
        end
    endtask

    task automatic test_reinit();
        logic       t_a0[4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic [7:0] t_d[4]  = '{8'h10, 8'h48, 8'h17, 8'h0B};
        logic [2:0] t_st[4] = '{ST_ICW2, ST_ICW3, ST_ICW2, ST_ICW2};
        int no, np, xo, xp;
        for (int i = 0; i < 4; i++) begin
            bus_write(t_a0[i], t_d[i], no, np);
            model_commit(t_a0[i], t_d[i], xo, xp);
            n_cmp++;
            if (dut_vec() !== exp_vec() || seq_state !== t_st[i] || no !== 0 || np !== 0) begin
                n_fail++; $display("FAIL reinit step%0d: got %h st=%0d want %h st=%0d", i, dut_vec(), seq_state, exp_vec(), t_st[i]);
            end
        end
        n_cmp++;
        if (imr !== 8'h00 || sngl !== 1 || ic4 !== 1) begin
            n_fail++; $display("FAIL reinit_final: got imr=%h sngl=%b ic4=%b want 00 1 1", imr, sngl, ic4);
        end
    endtask

    task automatic test_abort();
        int no, np;
        for (int k = 0; k < 2; k++) begin
            bus_abort(k, 1'b1, 8'hF8, no, np);
            n_cmp++;
            if (dut_vec() !== exp_vec() || seq_state !== ST_ICW2) begin
                n_fail++; $display("FAIL abort kind%0d: got %h want %h", k, dut_vec(), exp_vec());
            end
        end
        @(negedge clk);
        rstn = 0;
        model_reset();
        @(negedge clk);
        rstn = 1;
        bus_write(1'b1, 8'h12, no, np);
        n_cmp++;
        if (dut_vec() !== exp_vec() || seq_state !== ST_IDLE || imr !== 8'hFF) begin
            n_fail++; $display("FAIL idle_a0_write: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_reset_mid_strobe();
        int no, np, xo, xp;
        bus_write(1'b0, 8'h12, no, np);
        model_commit(1'b0, 8'h12, xo, xp);
        bus_write(1'b1, 8'h30, no, np);
        model_commit(1'b1, 8'h30, xo, xp);
        n_cmp++;
        if (seq_state !== ST_READY || dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL pre_reset_ready: got %h want %h", dut_vec(), exp_vec());
        end
        @(negedge clk);
        csn = 0; wrn = 0; rdn = 1; a0 = 0; din = 8'h1B;
        @(negedge clk);
        #1 rstn = 0;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++; $display("FAIL reset_mid_strobe: got %h want %h", dut_vec(), exp_vec());
        end
        @(negedge clk);
        rstn = 1; wrn = 1; csn = 1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (dut_vec() !== exp_vec() || seq_state !== ST_IDLE) begin
            n_fail++; $display("FAIL no_commit_after_reset: got %h want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int no, np, xo, xp, pick;
        logic       ra0;
        logic [7:0] rd;
        @(negedge clk);
        rstn = 0;
        model_reset();
        @(negedge clk);
        rstn = 1;
        for (int i = 0; i < 300; i++) begin
            pick = $urandom_range(0, 9);
            ra0 = 1'($urandom);
            rd = 8'($urandom);
            if (pick == 0) begin
                ra0 = 0; rd[4] = 1;
            end
            if (pick == 1) begin
                bus_abort($urandom_range(0, 1), ra0, rd, no, np);
                xo = 0; xp = 0;
            end else begin
                bus_write(ra0, rd, no, np);
                model_commit(ra0, rd, xo, xp);
            end
            n_cmp++;
            if (dut_vec() !== exp_vec() || no !== xo || np !== xp) begin
                n_fail++; $display("FAIL random_%0d a0=%b d=%h: got %h o%0d p%0d want %h o%0d p%0d",
                                   i, ra0, rd, dut_vec(), no, np, exp_vec(), xo, xp);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_init_single_ic4();
        test_init_cascade();
        test_ready_ocws();
        test_reinit();
        test_abort();
        test_reset_mid_strobe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
